// File: rtl/ps2_key_mover.sv
// ps2_key_mover: PS/2 keyboard front end that moves an on-screen object and
// selects its colour.
//   - two-flop synchronisers on PS2_CLK / PS2_DATA, falling-edge detect
//   - frame receiver (start, 8 data bits LSB first, odd parity, stop) with
//     an inter-edge timeout
//   - E0 / F0 prefix decoder producing one key event per non-prefix byte
//   - radius-aware, bounded movement on arrow keys and two-stage colour select
// Optional build macro: TYPEMATIC_MOVE_EN makes arrow keys move on press
// events (typematic repeat gives continuous motion) instead of on release.
module ps2_key_mover #(
  parameter int POS_W       = 11,
  parameter int X_MAX       = 640,
  parameter int Y_MAX       = 480,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240,
  parameter int STEP        = 5,
  parameter int MARGIN      = 5,
  parameter int RSCALE      = 5,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             PS2_CLK,
  input  logic             PS2_DATA,
  input  logic [2:0]       radius,
  output logic [1:0]       color,
  output logic [POS_W-1:0] ball_x,
  output logic [POS_W-1:0] ball_y,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_break,
  output logic             key_ext,
  output logic             frame_err
);

  localparam int BW   = POS_W + 2;
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic signed [BW-1:0] STEP_S   = BW'(STEP);
  localparam logic signed [BW-1:0] MARGIN_S = BW'(MARGIN);
  localparam logic signed [BW-1:0] XLIM_S   = BW'(X_MAX - MARGIN);
  localparam logic signed [BW-1:0] YLIM_S   = BW'(Y_MAX - MARGIN);
  localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;
  localparam logic [7:0] CODE_COL1  = 8'h16;
  localparam logic [7:0] CODE_COL2  = 8'h1E;
  localparam logic [7:0] CODE_COL3  = 8'h26;
  localparam logic [7:0] CODE_ENTER = 8'h5A;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // synchroniser and edge-detect state
  logic clk_ff1, clk_ff2, clk_prev;
  logic dat_ff1, dat_ff2;
  logic ps2_fall;

  // receiver state
  rx_state_t       rx_state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;
  logic            byte_ok;
  logic [7:0]      rx_byte;

  // decoder state
  logic ext_pend, brk_pend;

  // movement / colour state
  logic       move_evt;
  logic [1:0] pending;
  logic       up_ok, down_ok, left_ok, right_ok;
  logic signed [BW-1:0] x_s, y_s, r_s;

  // Two-flop synchronisers plus one history flop for edge detection; idle-high reset
  always_ff @(posedge CLK) begin
    if (reset) begin
      clk_ff1  <= 1'b1;
      clk_ff2  <= 1'b1;
      clk_prev <= 1'b1;
      dat_ff1  <= 1'b1;
      dat_ff2  <= 1'b1;
    end else begin
      clk_ff1  <= PS2_CLK;
      clk_ff2  <= clk_ff1;
      clk_prev <= clk_ff2;
      dat_ff1  <= PS2_DATA;
      dat_ff2  <= dat_ff1;
    end
  end

  assign ps2_fall = clk_prev & ~clk_ff2;

  // Frame receiver FSM with inter-edge timeout; byte_ok / frame_err are one-cycle pulses
  always_ff @(posedge CLK) begin
    if (reset) begin
      rx_state  <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      byte_ok   <= 1'b0;
      rx_byte   <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_ok   <= 1'b0;
      frame_err <= 1'b0;

      if (rx_state == IDLE || ps2_fall) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (rx_state != IDLE && !ps2_fall && to_cnt == TO_LAST) begin
        // keyboard went quiet mid-frame: drop the partial byte
        frame_err <= 1'b1;
        rx_state  <= IDLE;
        to_cnt    <= '0;
      end else if (ps2_fall) begin
        unique case (rx_state)
          IDLE: begin
            if (!dat_ff2) begin
              rx_state <= DATA;
              bit_cnt  <= '0;
            end
          end
          DATA: begin
            shift_reg <= {dat_ff2, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              rx_state <= PARITY;
            end
          end
          PARITY: begin
            par_bit  <= dat_ff2;
            rx_state <= STOP;
          end
          STOP: begin
            if ((^{shift_reg, par_bit}) && dat_ff2) begin
              byte_ok <= 1'b1;
              rx_byte <= shift_reg;
            end else begin
              frame_err <= 1'b1;
            end
            rx_state <= IDLE;
          end
          default: rx_state <= IDLE;
        endcase
      end
    end
  end

  // Prefix decoder: E0/F0 arm pending flags, any other byte emits a key event
  always_ff @(posedge CLK) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      key_break <= 1'b0;
      key_ext   <= 1'b0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_err) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_ok) begin
        if (rx_byte == CODE_EXT) begin
          ext_pend <= 1'b1;
        end else if (rx_byte == CODE_BRK) begin
          brk_pend <= 1'b1;
        end else begin
          key_valid <= 1'b1;
          key_code  <= rx_byte;
          key_break <= brk_pend;
          key_ext   <= ext_pend;
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
        end
      end
    end
  end

`ifdef TYPEMATIC_MOVE_EN
  assign move_evt = key_valid & ~key_break;
`else
  assign move_evt = key_valid & key_break;
`endif

  // Signed bound checks at POS_W+2 bits so the subtractions cannot wrap
  always_comb begin
    x_s      = $signed({2'b00, ball_x});
    y_s      = $signed({2'b00, ball_y});
    r_s      = $signed(BW'(radius) * BW'(RSCALE));
    up_ok    = (y_s - STEP_S - r_s) >= MARGIN_S;
    down_ok  = (y_s + STEP_S + r_s) <= YLIM_S;
    left_ok  = (x_s - STEP_S - r_s) >= MARGIN_S;
    right_ok = (x_s + STEP_S + r_s) <= XLIM_S;
  end

  // Object position: one step per accepted arrow event, out-of-bound moves dropped
  always_ff @(posedge CLK) begin
    if (reset) begin
      ball_x <= POS_W'(X_INIT);
      ball_y <= POS_W'(Y_INIT);
    end else if (move_evt) begin
      if (key_code == CODE_UP && up_ok) begin
        ball_y <= ball_y - POS_W'(STEP);
      end
      if (key_code == CODE_DOWN && down_ok) begin
        ball_y <= ball_y + POS_W'(STEP);
      end
      if (key_code == CODE_LEFT && left_ok) begin
        ball_x <= ball_x - POS_W'(STEP);
      end
      if (key_code == CODE_RIGHT && right_ok) begin
        ball_x <= ball_x + POS_W'(STEP);
      end
    end
  end

  // Colour select: number keys pick a pending colour, Enter commits it (release only)
  always_ff @(posedge CLK) begin
    if (reset) begin
      color   <= 2'd1;
      pending <= 2'd1;
    end else if (key_valid && key_break) begin
      if (key_code == CODE_COL1) begin
        pending <= 2'd1;
      end
      if (key_code == CODE_COL2) begin
        pending <= 2'd2;
      end
      if (key_code == CODE_COL3) begin
        pending <= 2'd3;
      end
      if (key_code == CODE_ENTER) begin
        color <= pending;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_mover.sv
// Testbench for ps2_key_mover: directed PS/2 frames, a key-level model of the
// decoder/mover/colour logic, and one compare process on the falling CLK edge.
module tb_ps2_key_mover;

  localparam int TO_CYC = 200;
  localparam int H      = 5;     // CLK cycles per PS/2 clock half-period

  logic        CLK = 1'b0;
  logic        reset;
  logic        PS2_CLK;
  logic        PS2_DATA;
  logic [2:0]  radius;
  logic [1:0]  color;
  logic [10:0] ball_x;
  logic [10:0] ball_y;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        key_break;
  logic        key_ext;
  logic        frame_err;

  ps2_key_mover #(.TIMEOUT_CYC(TO_CYC)) dut (
    .CLK      (CLK),
    .reset    (reset),
    .PS2_CLK  (PS2_CLK),
    .PS2_DATA (PS2_DATA),
    .radius   (radius),
    .color    (color),
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_break(key_break),
    .key_ext  (key_ext),
    .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- key-level model ----------------
  typedef struct {
    int code;
    int brk;
    int ext;
    int x;
    int y;
    int col;
  } ev_t;

  ev_t evq[$];
  int  mx, my, mcol, mpend, m_ext, m_brk;
  int  err_exp  = 0;
  int  err_seen = 0;
  bit  chk_en   = 0;

  function automatic void model_reset();
    mx = 320; my = 240; mcol = 1; mpend = 1; m_ext = 0; m_brk = 0;
  endfunction

  function automatic void model_err();
    m_ext = 0; m_brk = 0; err_exp++;
  endfunction

  function automatic void model_byte(input int b);
    int  r;
    bit  mv;
    ev_t e;
    if (b == 'hE0) m_ext = 1;
    else if (b == 'hF0) m_brk = 1;
    else begin
      r = int'(radius) * 5;
`ifdef TYPEMATIC_MOVE_EN
      mv = (m_brk == 0);
`else
      mv = (m_brk == 1);
`endif
      if (mv) begin
        if (b == 'h75 && my - 5 - r >= 5)   my -= 5;
        if (b == 'h72 && my + 5 + r <= 475) my += 5;
        if (b == 'h6B && mx - 5 - r >= 5)   mx -= 5;
        if (b == 'h74 && mx + 5 + r <= 635) mx += 5;
      end
      if (m_brk == 1) begin
        if (b == 'h16) mpend = 1;
        if (b == 'h1E) mpend = 2;
        if (b == 'h26) mpend = 3;
        if (b == 'h5A) mcol = mpend;
      end
      e.code = b; e.brk = m_brk; e.ext = m_ext;
      e.x = mx; e.y = my; e.col = mcol;
      evq.push_back(e);
      m_ext = 0; m_brk = 0;
    end
  endfunction

  // ---------------- compare process ----------------
  ev_t post;
  bit  post_chk = 0;

  always @(negedge CLK) begin
    if (post_chk) begin
      chk("post_x", int'(ball_x), post.x);
      chk("post_y", int'(ball_y), post.y);
      chk("post_col", int'(color), post.col);
      post_chk = 0;
    end
    if (frame_err) err_seen++;
    if (key_valid) begin
      if (evq.size() == 0) begin
        chk("unexpected_key", int'(key_code), -1);
      end else begin
        post = evq.pop_front();
        chk("ev_code", int'(key_code), post.code);
        chk("ev_break", int'(key_break), post.brk);
        chk("ev_ext", int'(key_ext), post.ext);
        post_chk = 1;
      end
    end
    if (chk_en) begin
      chk("x", int'(ball_x), mx);
      chk("y", int'(ball_y), my);
      chk("col", int'(color), mcol);
      chk("quiet", int'({key_valid, frame_err}), 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic tx_raw(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    logic        p;
    p  = bad_par ? (^b) : ~(^b);
    fr = {1'b1, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_DATA = fr[i];
      cyc(H);
      PS2_CLK = 1'b0;
      cyc(H);
      PS2_CLK = 1'b1;
    end
    cyc(H);
    PS2_DATA = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    chk_en = 0;
    model_byte(int'(b));
    tx_raw(b, 1'b0, 11);
    cyc(10);
    chk_en = 1;
  endtask

  task automatic arrow(input logic [7:0] code);
`ifndef TYPEMATIC_MOVE_EN
    send_byte(8'hF0);
`endif
    send_byte(code);
  endtask

  task automatic release_key(input logic [7:0] code);
    send_byte(8'hF0);
    send_byte(code);
  endtask

  initial begin
    reset    = 1'b1;
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
    radius   = 3'd0;
    model_reset();
    cyc(4);
    reset = 1'b0;
    cyc(2);

    // reset state
    chk("rst_x", int'(ball_x), 320);
    chk("rst_y", int'(ball_y), 240);
    chk("rst_col", int'(color), 1);
    chk("rst_code", int'(key_code), 0);
    chk("rst_flags", int'({key_valid, key_break, key_ext, frame_err}), 0);
    chk_en = 1;

    // up arrow, radius 0
    arrow(8'h75);
    chk("up_y", int'(ball_y), 235);
    chk("up_code", int'(key_code), 'h75);

    // right arrow against the right bound with R=35
    radius = 3'd7;
    repeat (55) arrow(8'h74);
    chk("rt_595", int'(ball_x), 595);
    arrow(8'h74);
    chk("rt_600", int'(ball_x), 600);
    arrow(8'h74);
    chk("rt_hold", int'(ball_x), 600);

    // bad parity on a colour key after F0: error, pends cleared, pending unchanged
    send_byte(8'hF0);
    chk_en = 0;
    model_err();
    tx_raw(8'h1E, 1'b1, 11);
    cyc(10);
    chk_en = 1;
    chk("par_err", err_seen, err_exp);
    release_key(8'h5A);
    chk("par_col", int'(color), 1);

    // timeout after four data bits, then a clean colour selection
    chk_en = 0;
    model_err();
    tx_raw(8'h1E, 1'b0, 5);
    cyc(TO_CYC + 20);
    chk_en = 1;
    chk("to_err", err_seen, err_exp);
    release_key(8'h1E);
    release_key(8'h5A);
    chk("to_col", int'(color), 2);

    // extended release of left arrow, then a plain make code
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    chk("ext_flag", int'(key_ext), 1);
    chk("ext_brk", int'(key_break), 1);
`ifdef TYPEMATIC_MOVE_EN
    chk("ext_x", int'(ball_x), 600);
`else
    chk("ext_x", int'(ball_x), 595);
`endif
    send_byte(8'h6B);
    chk("mk_brk", int'(key_break), 0);
    chk("mk_ext", int'(key_ext), 0);
    chk("mk_x", int'(ball_x), 595);

    // reset while the receiver waits for the parity bit
    chk_en = 0;
    tx_raw(8'h55, 1'b0, 9);
    reset    = 1'b1;
    PS2_DATA = 1'b1;
    cyc(3);
    reset = 1'b0;
    model_reset();
    cyc(1);
    chk("mr_x", int'(ball_x), 320);
    chk("mr_y", int'(ball_y), 240);
    chk("mr_col", int'(color), 1);
    chk("mr_code", int'(key_code), 0);
    chk("mr_flags", int'({key_valid, key_break, key_ext, frame_err}), 0);
    chk_en = 1;
    release_key(8'h26);
    release_key(8'h5A);
    chk("mr_col3", int'(color), 3);
    chk("mr_code2", int'(key_code), 'h5A);

    cyc(5);
    chk("evq_empty", evq.size(), 0);
    chk("err_total", err_seen, err_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
